// File: rtl/system_mem_arbiter_if.sv
// ============================================================================
//  Module      : system_mem_arbiter_if
//  Description : Bundle of the CPU, video and memory-side signals of the
//                system memory arbiter.
//                slave  - arbiter view (requests in, grants/data out,
//                         drives the memory port)
//                master - requester/environment view (the mirror image)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface system_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  // CPU port (read/write)
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  // Video port (read-only)
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  // Memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/system_mem_arbiter.sv
// ============================================================================
//  Module      : system_mem_arbiter
//  Description : Two-port arbiter sharing one memory port between the CPU
//                (read/write) and the video fetcher (read-only). One access
//                is issued per cycle; read owners travel down a tag pipe so
//                returning data is flagged to the port that asked for it.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - system_mem_arbiter_if.slave (CPU, video, memory)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module system_mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LAT     = 2,
  parameter int unsigned VID_PRIORITY = 1,
  parameter int unsigned STARVE_MAX   = 8
) (
  input  wire                  clk,
  input  wire                  rst_n,
  system_mem_arbiter_if.slave  bus
);

  logic w_cpu_pick;   // arbitration decision, before reset gating
  logic w_vid_pick;
  logic w_cpu_win;    // final grants
  logic w_vid_win;
  logic w_issue_rd;

  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;

  // Stage k of the pipe describes the read issued k+1 cycles ago, so stage
  // READ_LAT lines up with the memory returning that read's data.
  logic [READ_LAT:0] r_pipe_vld;
  logic [READ_LAT:0] r_pipe_vid;  // owner tag: 1 = video, 0 = CPU

  generate
    if (VID_PRIORITY != 0) begin : g_prio
      localparam int unsigned    c_STARVE_W   = $clog2(STARVE_MAX + 1);
      localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

      logic [c_STARVE_W-1:0] r_starve_cnt;

      // Video wins unless the CPU has been refused STARVE_MAX times in a row.
      assign w_cpu_pick = bus.cpu_req && (!bus.vid_req || (r_starve_cnt == c_STARVE_MAX));
      assign w_vid_pick = bus.vid_req && !w_cpu_pick;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_starve_cnt <= '0;
        end else if (!bus.cpu_req || w_cpu_win) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
    end else begin : g_rr
      logic r_last_vid;  // last grant went to video; reset value = CPU

      assign w_cpu_pick = bus.cpu_req && (!bus.vid_req || r_last_vid);
      assign w_vid_pick = bus.vid_req && !w_cpu_pick;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_last_vid <= 1'b0;
        end else if (w_cpu_win) begin
          r_last_vid <= 1'b0;
        end else if (w_vid_win) begin
          r_last_vid <= 1'b1;
        end
      end
    end
  endgenerate

  // Grants are combinational and held low for the whole reset pulse.
  assign w_cpu_win  = rst_n && w_cpu_pick;
  assign w_vid_win  = rst_n && w_vid_pick;
  assign w_issue_rd = (w_cpu_win && !bus.cpu_we) || w_vid_win;

  // Memory request register: address and write data hold when nobody is
  // granted; the write strobe is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_cpu_win && bus.cpu_we;
      if (w_cpu_win) begin
        r_mem_addr  <= bus.cpu_addr;
        r_mem_wdata <= bus.cpu_wdata;
      end else if (w_vid_win) begin
        r_mem_addr  <= bus.vid_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      r_pipe_vid <= '0;
    end else begin
      r_pipe_vld <= {r_pipe_vld[READ_LAT-1:0], w_issue_rd};
      r_pipe_vid <= {r_pipe_vid[READ_LAT-1:0], w_vid_win};
    end
  end

  assign bus.cpu_gnt    = w_cpu_win;
  assign bus.vid_gnt    = w_vid_win;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.cpu_rvalid = r_pipe_vld[READ_LAT] && !r_pipe_vid[READ_LAT];
  assign bus.vid_rvalid = r_pipe_vld[READ_LAT] &&  r_pipe_vid[READ_LAT];
  // Read data is a straight pass-through; only the owner's rvalid qualifies it.
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.vid_rdata  = bus.mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_system_mem_arbiter.sv
// ============================================================================
//  Module      : tb_system_mem_arbiter
//  Description : Bench for system_mem_arbiter. Two instances run side by side
//                from identical transaction lists: index 0 uses video
//                priority with starvation guard, index 1 uses round-robin.
//                A bench memory with a two-cycle read pipe serves each one.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_system_mem_arbiter;
  localparam int AW = 16, DW = 8, LAT = 2, SMAX = 8, HLEN = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         cpu_req, cpu_we, vid_req;
  logic [1:0][AW-1:0] cpu_addr, vid_addr, mem_addr;
  logic [1:0][DW-1:0] cpu_wdata, cpu_rdata, vid_rdata, mem_wdata, rd0, rd1;
  logic [1:0]         cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, mem_we;

  system_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  system_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  system_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT), .VID_PRIORITY(1), .STARVE_MAX(SMAX))
    u_prio (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  system_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT), .VID_PRIORITY(0), .STARVE_MAX(SMAX))
    u_rr (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  assign bus0.cpu_req = cpu_req[0];   assign bus1.cpu_req = cpu_req[1];
  assign bus0.cpu_we = cpu_we[0];     assign bus1.cpu_we = cpu_we[1];
  assign bus0.cpu_addr = cpu_addr[0]; assign bus1.cpu_addr = cpu_addr[1];
  assign bus0.cpu_wdata = cpu_wdata[0]; assign bus1.cpu_wdata = cpu_wdata[1];
  assign bus0.vid_req = vid_req[0];   assign bus1.vid_req = vid_req[1];
  assign bus0.vid_addr = vid_addr[0]; assign bus1.vid_addr = vid_addr[1];
  assign bus0.mem_rdata = rd1[0];     assign bus1.mem_rdata = rd1[1];
  assign cpu_gnt[0] = bus0.cpu_gnt;   assign cpu_gnt[1] = bus1.cpu_gnt;
  assign vid_gnt[0] = bus0.vid_gnt;   assign vid_gnt[1] = bus1.vid_gnt;
  assign cpu_rvalid[0] = bus0.cpu_rvalid; assign cpu_rvalid[1] = bus1.cpu_rvalid;
  assign vid_rvalid[0] = bus0.vid_rvalid; assign vid_rvalid[1] = bus1.vid_rvalid;
  assign cpu_rdata[0] = bus0.cpu_rdata;   assign cpu_rdata[1] = bus1.cpu_rdata;
  assign vid_rdata[0] = bus0.vid_rdata;   assign vid_rdata[1] = bus1.vid_rdata;
  assign mem_addr[0] = bus0.mem_addr;     assign mem_addr[1] = bus1.mem_addr;
  assign mem_we[0] = bus0.mem_we;         assign mem_we[1] = bus1.mem_we;
  assign mem_wdata[0] = bus0.mem_wdata;   assign mem_wdata[1] = bus1.mem_wdata;

  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
  typedef struct { int d; int due; bit vid; logic [DW-1:0] data; } ev_t;

  req_t cq0[$], cq1[$], vq0[$], vq1[$];
  ev_t  evq[$];
  int   cyc = 0;
  int   errors = 0, checks = 0;
  bit   [1:0] cg_seen = '0, vg_seen = '0;

  // Observation logs for the hand-computed checks
  logic [1:0] ghist  [2][HLEN];   // {cpu_gnt, vid_gnt}
  logic       wehist [2][HLEN];
  logic [AW-1:0] ahist [2][HLEN];
  int cpu_rv_cnt[2], vid_rv_cnt[2], cpu_rv_cyc[2], vid_rv_cyc[2];
  logic [DW-1:0] cpu_rv_dat[2], vid_rv_dat[2];

  function automatic logic [DW-1:0] init_val(int a);
    logic [15:0] x;
    x = a[15:0];
    case (x)
      16'h1234: return 8'hA5;
      16'h8000: return 8'h11;
      16'h8001: return 8'h22;
      default:  return x[7:0] ^ x[15:8] ^ 8'h5A;
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", nm, d, cyc, act, exp);
    end
  endtask

  // ---------------- bench memory: data valid two cycles after mem_addr ----
  logic [DW-1:0] bmem [2][65536];
  initial begin
    for (int a = 0; a < 65536; a++) begin
      bmem[0][a] = init_val(a);
      bmem[1][a] = init_val(a);
    end
    rd0 = '0; rd1 = '0;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        rd1[d] = rd0[d];
        rd0[d] = bmem[d][mem_addr[d]];
        if (mem_we[d]) bmem[d][mem_addr[d]] = mem_wdata[d];
      end
    end
  end

  // ---------------- request driver: present queue heads, pop on grant -----
  initial begin
    cpu_req = '0; cpu_we = '0; vid_req = '0;
    cpu_addr = '0; cpu_wdata = '0; vid_addr = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cg_seen[0]) void'(cq0.pop_front());
      if (cg_seen[1]) void'(cq1.pop_front());
      if (vg_seen[0]) void'(vq0.pop_front());
      if (vg_seen[1]) void'(vq1.pop_front());
      cpu_req[0] = (cq0.size() != 0);
      if (cq0.size() != 0) begin cpu_we[0] = cq0[0].we; cpu_addr[0] = cq0[0].addr; cpu_wdata[0] = cq0[0].wdata; end
      cpu_req[1] = (cq1.size() != 0);
      if (cq1.size() != 0) begin cpu_we[1] = cq1[0].we; cpu_addr[1] = cq1[0].addr; cpu_wdata[1] = cq1[0].wdata; end
      vid_req[0] = (vq0.size() != 0);
      if (vq0.size() != 0) vid_addr[0] = vq0[0].addr;
      vid_req[1] = (vq1.size() != 0);
      if (vq1.size() != 0) vid_addr[1] = vq1[0].addr;
    end
  end

  // ---------------- transaction-level model and per-cycle compare --------
  initial begin : compare
    logic [DW-1:0] shadow [2][65536];
    int starve[2];
    bit last_cpu[2];
    logic [AW-1:0] exp_addr[2];
    logic [DW-1:0] exp_wd[2];
    bit exp_we[2];
    bit ec, ev, e_cv, e_vv;
    logic [DW-1:0] e_cd, e_vd;
    int c;
    for (int a = 0; a < 65536; a++) begin
      shadow[0][a] = init_val(a);
      shadow[1][a] = init_val(a);
    end
    for (int d = 0; d < 2; d++) begin
      starve[d] = 0; last_cpu[d] = 1; exp_addr[d] = '0; exp_wd[d] = '0; exp_we[d] = 0;
      cpu_rv_cnt[d] = 0; vid_rv_cnt[d] = 0; cpu_rv_cyc[d] = -1; vid_rv_cyc[d] = -1;
      cpu_rv_dat[d] = '0; vid_rv_dat[d] = '0;
    end
    forever begin
      @(negedge clk);
      c = cyc;
      for (int d = 0; d < 2; d++) begin
        if (c < HLEN) begin
          ghist[d][c] = {cpu_gnt[d], vid_gnt[d]};
          wehist[d][c] = mem_we[d];
          ahist[d][c] = mem_addr[d];
        end
        if (!rst_n) begin
          chk("gnt_in_reset", d, {cpu_gnt[d], vid_gnt[d]}, 0);
          chk("mem_we_in_reset", d, mem_we[d], 0);
          chk("rvalid_in_reset", d, {cpu_rvalid[d], vid_rvalid[d]}, 0);
          chk("mem_addr_in_reset", d, mem_addr[d], 0);
          starve[d] = 0; last_cpu[d] = 1; exp_addr[d] = '0; exp_wd[d] = '0; exp_we[d] = 0;
          cg_seen[d] = 0; vg_seen[d] = 0;
        end else begin
          // Expected grant from the arbitration rules of this instance
          if (d == 0) ec = cpu_req[d] && (!vid_req[d] || starve[d] == SMAX);
          else        ec = cpu_req[d] && (!vid_req[d] || !last_cpu[d]);
          ev = vid_req[d] && !ec;
          chk("cpu_gnt", d, cpu_gnt[d], ec);
          chk("vid_gnt", d, vid_gnt[d], ev);
          chk("mem_we", d, mem_we[d], exp_we[d]);
          chk("mem_addr", d, mem_addr[d], exp_addr[d]);
          chk("mem_wdata", d, mem_wdata[d], exp_wd[d]);
          e_cv = 0; e_vv = 0; e_cd = '0; e_vd = '0;
          foreach (evq[i]) begin
            if (evq[i].d == d && evq[i].due == c) begin
              if (evq[i].vid) begin e_vv = 1; e_vd = evq[i].data; end
              else begin e_cv = 1; e_cd = evq[i].data; end
            end
          end
          chk("cpu_rvalid", d, cpu_rvalid[d], e_cv);
          chk("vid_rvalid", d, vid_rvalid[d], e_vv);
          if (e_cv) chk("cpu_rdata", d, cpu_rdata[d], e_cd);
          if (e_vv) chk("vid_rdata", d, vid_rdata[d], e_vd);
          if (cpu_rvalid[d]) begin cpu_rv_cnt[d]++; cpu_rv_cyc[d] = c; cpu_rv_dat[d] = cpu_rdata[d]; end
          if (vid_rvalid[d]) begin vid_rv_cnt[d]++; vid_rv_cyc[d] = c; vid_rv_dat[d] = vid_rdata[d]; end
          // Advance the model with the expected winner
          starve[d] = (!cpu_req[d] || ec) ? 0 : ((starve[d] < SMAX) ? starve[d] + 1 : SMAX);
          exp_we[d] = 0;
          if (ec) begin
            last_cpu[d] = 1;
            exp_addr[d] = cpu_addr[d];
            exp_wd[d] = cpu_wdata[d];
            exp_we[d] = cpu_we[d];
            if (cpu_we[d]) shadow[d][cpu_addr[d]] = cpu_wdata[d];
            else evq.push_back('{d, c + 1 + LAT, 1'b0, shadow[d][cpu_addr[d]]});
          end else if (ev) begin
            last_cpu[d] = 0;
            exp_addr[d] = vid_addr[d];
            evq.push_back('{d, c + 1 + LAT, 1'b1, shadow[d][vid_addr[d]]});
          end
          cg_seen[d] = cpu_gnt[d];
          vg_seen[d] = vid_gnt[d];
        end
      end
      if (!rst_n) evq.delete();
      for (int i = evq.size() - 1; i >= 0; i--)
        if (evq[i].due <= c) evq.delete(i);
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    cq0.push_back('{we, a, wd});
    cq1.push_back('{we, a, wd});
  endtask

  task automatic push_vid(input logic [AW-1:0] a);
    vq0.push_back('{1'b0, a, 8'h00});
    vq1.push_back('{1'b0, a, 8'h00});
  endtask

  task automatic drain();
    int n = 0;
    while ((cq0.size() + cq1.size() + vq0.size() + vq1.size()) != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("queues_drained_in_budget", 0, (n < 200), 1);
    tick(LAT + 4);
  endtask

  initial begin : stim
    int base, cnt0, cnt1;
    tick(3);
    @(posedge clk); #2 rst_n = 1'b1;
    tick(2);
    chk("post_reset_mem_addr", 0, mem_addr[0], 16'h0000);
    chk("post_reset_mem_we", 1, mem_we[1], 0);

    // CPU read of 0x1234 on an idle bus
    base = cyc + 1;
    push_cpu(0, 16'h1234, 8'h00);
    drain();
    chk("t1_gnt_cycle0", 0, ghist[0][base], 2'b10);
    chk("t1_mem_addr_cycle1", 0, ahist[0][base+1], 16'h1234);
    chk("t1_rvalid_cycle3", 0, cpu_rv_cyc[0], base + 3);
    chk("t1_rdata", 0, cpu_rv_dat[0], 8'hA5);
    chk("t1_rdata", 1, cpu_rv_dat[1], 8'hA5);
    chk("t1_no_vid_rvalid", 0, vid_rv_cnt[0], 0);

    // Write 0x3C to 0x0010 then read it back the next cycle
    base = cyc + 1;
    push_cpu(1, 16'h0010, 8'h3C);
    push_cpu(0, 16'h0010, 8'h00);
    drain();
    chk("t2_mem_we_cycle1", 0, wehist[0][base+1], 1);
    chk("t2_mem_we_cycle2", 0, wehist[0][base+2], 0);
    chk("t2_raw_cycle", 0, cpu_rv_cyc[0], base + 4);
    chk("t2_raw_data", 0, cpu_rv_dat[0], 8'h3C);

    // Interleaved video 0x8000 / CPU 0x8001 reads
    base = cyc + 1;
    push_vid(16'h8000);
    push_cpu(0, 16'h8001, 8'h00);
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("t5_vid_cycle", d, vid_rv_cyc[d], base + 3);
      chk("t5_vid_data", d, vid_rv_dat[d], 8'h11);
      chk("t5_cpu_cycle", d, cpu_rv_cyc[d], base + 4);
      chk("t5_cpu_data", d, cpu_rv_dat[d], 8'h22);
    end

    // Leave video as the last winner, then both ports request continuously
    push_vid(16'h0100);
    drain();
    base = cyc + 1;
    for (int i = 0; i < 20; i++) begin
      push_cpu(0, 16'h2000 + 16'(i), 8'h00);
      push_vid(16'h3000 + 16'(i));
    end
    drain();
    for (int i = 0; i < 8; i++) chk("t3_vid_run", 0, ghist[0][base+i], 2'b01);
    chk("t3_starve_cpu", 0, ghist[0][base+8], 2'b10);
    chk("t3_vid_resume", 0, ghist[0][base+9], 2'b01);
    chk("t3_repeat_cpu", 0, ghist[0][base+17], 2'b10);
    for (int i = 0; i < 4; i++) chk("t4_alternate", 1, ghist[1][base+i], (i % 2 == 0) ? 2'b10 : 2'b01);

    // Mixed back-to-back writes and reads contending with video reads
    for (int i = 0; i < 8; i++) begin
      push_cpu((i % 2) == 0, 16'h4000 + 16'(i / 2), 8'h80 + 8'(i));
      push_vid(16'h4000 + 16'(i % 4));
    end
    drain();

    // Reset in the cycle after a read grant: the read must never return
    base = cyc + 1;
    push_cpu(0, 16'h5555, 8'h00);
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    cnt0 = cpu_rv_cnt[0]; cnt1 = cpu_rv_cnt[1];
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    tick(8);
    chk("t6_gnt_before_reset", 0, ghist[0][base], 2'b10);
    chk("t6_no_rvalid", 0, cpu_rv_cnt[0], cnt0);
    chk("t6_no_rvalid", 1, cpu_rv_cnt[1], cnt1);
    base = cyc + 1;
    push_cpu(0, 16'h1234, 8'h00);
    drain();
    chk("t6_post_reset_gnt", 0, ghist[0][base], 2'b10);
    chk("t6_post_reset_rdata", 1, cpu_rv_dat[1], 8'hA5);
    chk("t6_post_reset_cycle", 1, cpu_rv_cyc[1], base + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
